// File: rtl/pkg_1553.sv
// Shared MIL-STD-1553 framing constants and FSM encoding for the encoder/decoder pair.
package pkg_1553;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_e;

  localparam int SYNC_HALF_BITS   = 6;
  localparam int DATA_HALF_BITS   = 32;
  localparam int PARITY_HALF_BITS = 2;

  // diff[0] level per sync half-bit, leftmost half-bit first
  localparam logic [5:0] SYNC_CMD  = 6'b111000;
  localparam logic [5:0] SYNC_DATA = 6'b000111;

  function automatic logic [1:0] to_diff(input logic lvl);
    return {~lvl, lvl};
  endfunction

endpackage

// File: rtl/util_1553_half_bit_tick.sv
// Half-bit timebase: one-cycle tick every H cycles, plus a pre-tick one cycle earlier.
module util_1553_half_bit_tick #(
  parameter int H = 50
) (
  input  logic aclk,
  input  logic arst,
  input  logic restart,
  output logic tick,
  output logic tick_pre
);

  localparam int CW = $clog2(H);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst)                cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign tick     = (cnt == CW'(H - 1));
  assign tick_pre = (cnt == CW'(H - 2));

endmodule

// File: rtl/axis_1553_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II word encoder with configurable inter-word gap.
module axis_1553_encoder
  import pkg_1553::*;
#(
  parameter int         CLOCK_SPEED = 100000000,
  parameter int         BIT_RATE    = 1000000,
  parameter int         GAP_BITS    = 4,
  parameter logic [1:0] IDLE_DIFF   = 2'b11
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  diff,
  output logic        busy,
  output logic        word_done
);

  localparam int H  = CLOCK_SPEED / (2 * BIT_RATE);
  localparam int GW = (GAP_BITS == 0) ? 1 : $clog2(2 * GAP_BITS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS == 0) ? 0 : 2 * GAP_BITS - 1);

  state_e        state;
  logic [4:0]    hb;
  logic [4:0]    hb_nx;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   data_q;
  logic [5:0]    sync_q;
  logic          par_q;
  logic          tick, tick_pre, hs;
  logic          unused_tuser;

  assign hs           = s_axis_tvalid & s_axis_tready;
  assign hb_nx        = hb + 5'd1;
  assign unused_tuser = ^s_axis_tuser[7:2];

  util_1553_half_bit_tick #(.H(H)) u_tick (
    .aclk     (aclk),
    .arst     (arst),
    .restart  (hs),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

  // diff is registered one half-bit ahead: each tick loads the level of the next half-bit
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state         <= IDLE;
      hb            <= '0;
      gap_cnt       <= '0;
      data_q        <= '0;
      sync_q        <= '0;
      par_q         <= 1'b0;
      diff          <= IDLE_DIFF;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      word_done     <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          diff <= IDLE_DIFF;
          if (hs) begin
            data_q        <= s_axis_tdata;
            sync_q        <= s_axis_tuser[0] ? SYNC_CMD : SYNC_DATA;
            par_q         <= ~^s_axis_tdata ^ s_axis_tuser[1];
            diff          <= to_diff(s_axis_tuser[0] ? SYNC_CMD[5] : SYNC_DATA[5]);
            hb            <= '0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b1;
            state         <= SYNC;
          end else begin
            s_axis_tready <= 1'b1;
          end
        end
        SYNC: if (tick) begin
          if (hb == 5'(SYNC_HALF_BITS - 1)) begin
            hb    <= '0;
            diff  <= to_diff(data_q[15]);
            state <= DATA;
          end else begin
            hb   <= hb_nx;
            diff <= to_diff(sync_q[3'd4 - hb[2:0]]);
          end
        end
        DATA: if (tick) begin
          if (hb == 5'(DATA_HALF_BITS - 1)) begin
            hb    <= '0;
            diff  <= to_diff(par_q);
            state <= PARITY;
          end else begin
            hb   <= hb_nx;
            diff <= to_diff(data_q[~hb_nx[4:1]] ^ hb_nx[0]);
          end
        end
        PARITY: begin
          if (tick_pre && hb[0]) word_done <= 1'b1;
          if (tick) begin
            if (hb == 5'(PARITY_HALF_BITS - 1)) begin
              hb   <= '0;
              diff <= IDLE_DIFF;
              if (GAP_BITS == 0) begin
                s_axis_tready <= 1'b1;
                busy          <= 1'b0;
                state         <= IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= GAP;
              end
            end else begin
              hb   <= hb_nx;
              diff <= to_diff(~par_q);
            end
          end
        end
        GAP: begin
          diff <= IDLE_DIFF;
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              s_axis_tready <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_1553_encoder.sv
// Directed bench for axis_1553_encoder at 100 MHz / 1 Mbit/s (H=50): one gapped and one gapless instance.
module tb_axis_1553_encoder;

  localparam int H    = 50;
  localparam int NCAP = 2401;

  logic        tb_data_clk = 1'b0;
  logic        arst;
  logic [15:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid, tvalid0;
  logic        rdy, rdy0, busy, busy0, wd, wd0;
  logic [1:0]  diff, diff0;

  int vectors    = 0;
  int miscompares = 0;

  logic [1:0] cap_diff [0:NCAP];
  logic       cap_rdy  [0:NCAP];
  logic       cap_busy [0:NCAP];
  logic       cap_wd   [0:NCAP];

  always #5 tb_data_clk = ~tb_data_clk;

  axis_1553_encoder #(.CLOCK_SPEED(100000000), .BIT_RATE(1000000), .GAP_BITS(4), .IDLE_DIFF(2'b11)) u_dut (
    .aclk(tb_data_clk), .arst(arst), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid), .s_axis_tready(rdy), .diff(diff), .busy(busy), .word_done(wd)
  );

  axis_1553_encoder #(.CLOCK_SPEED(100000000), .BIT_RATE(1000000), .GAP_BITS(0), .IDLE_DIFF(2'b11)) u_dut0 (
    .aclk(tb_data_clk), .arst(arst), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid0), .s_axis_tready(rdy0), .diff(diff0), .busy(busy0), .word_done(wd0)
  );

  // Expected diff[0] for half-bit k of a word (0..5 sync, 6..37 data, 38..39 parity)
  function automatic logic exp_lvl(input int k, input logic [15:0] d, input logic cmd, input logic par);
    logic b;
    if (k < 6) return cmd ? (k < 3) : (k >= 3);
    if (k < 38) begin
      b = d[15 - (k - 6) / 2];
      return (k % 2 == 0) ? b : ~b;
    end
    return (k == 38) ? par : ~par;
  endfunction

  // Send one word on the gapped instance; cycle c=1 is the first cycle after the handshake edge
  task automatic xfer(input logic [15:0] d, input logic [7:0] u);
    int w = 0;
    @(negedge tb_data_clk);
    while (!rdy && w < 5000) begin
      @(negedge tb_data_clk);
      w++;
    end
    if (!rdy) begin
      vectors++; miscompares++;
      $display("FAIL xfer_tready_timeout: tready=%b required 1", rdy);
    end
    tdata = d; tuser = u; tvalid = 1'b1;
    @(posedge tb_data_clk);
    #1 tvalid = 1'b0;
    for (int c = 1; c <= NCAP; c++) begin
      @(negedge tb_data_clk);
      cap_diff[c] = diff; cap_rdy[c] = rdy; cap_busy[c] = busy; cap_wd[c] = wd;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; tvalid = 1'b0; tvalid0 = 1'b0; tdata = '0; tuser = '0;
    repeat (3) @(negedge tb_data_clk);
    vectors++;
    if (diff !== 2'b11 || diff0 !== 2'b11) begin
      miscompares++; $display("FAIL reset_diff: got %b/%b required 11/11", diff, diff0);
    end
    vectors++;
    if (rdy !== 1'b0 || busy !== 1'b0 || wd !== 1'b0 || rdy0 !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: tready=%b busy=%b word_done=%b required 0", rdy, busy, wd);
    end
    arst = 1'b0;
    @(negedge tb_data_clk);
    vectors++;
    if (rdy !== 1'b1 || rdy0 !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_tready: got %b/%b required 1/1", rdy, rdy0);
    end
  endtask

  task automatic test_encode(input string name, input logic [15:0] d, input logic [7:0] u, input logic par);
    logic e;
    logic [1:0] bad_val;
    int bad, nwd, first;
    xfer(d, u);
    e = exp_lvl(0, d, u[0], par);
    vectors++;
    if (cap_diff[1] !== {~e, e}) begin
      miscompares++; $display("FAIL %s_latency: diff=%b required %b", name, cap_diff[1], {~e, e});
    end
    for (int k = 0; k < 40; k++) begin
      e = exp_lvl(k, d, u[0], par);
      bad = 0; bad_val = 2'b00;
      for (int j = 1; j <= H; j++)
        if (bad == 0 && cap_diff[k*H + j] !== {~e, e}) begin
          bad = k*H + j; bad_val = cap_diff[k*H + j];
        end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL %s_halfbit%0d: cycle %0d diff=%b required %b", name, k, bad, bad_val, {~e, e});
      end
    end
    nwd = 0; first = 0;
    for (int c = 1; c <= NCAP; c++)
      if (cap_wd[c] === 1'b1) begin
        nwd++;
        if (first == 0) first = c;
      end
    vectors++;
    if (nwd != 1 || first != 2000) begin
      miscompares++; $display("FAIL %s_word_done: %0d pulses first at %0d required 1 at 2000", name, nwd, first);
    end
    bad = 0;
    for (int c = 2001; c <= 2400; c++) if (cap_diff[c] !== 2'b11) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL %s_gap_diff: %0d gap cycles not 11 required 0", name, bad);
    end
    bad = 0;
    for (int c = 1; c <= 2400; c++) if (cap_busy[c] !== 1'b1 || cap_rdy[c] !== 1'b0) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL %s_busy_window: %0d cycles with busy!=1 or tready!=0 required 0", name, bad);
    end
    vectors++;
    if (cap_rdy[2401] !== 1'b1 || cap_busy[2401] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_tready_return: tready=%b busy=%b at 2401 required 1/0", name, cap_rdy[2401], cap_busy[2401]);
    end
  endtask

  task automatic test_back_to_back();
    int hs = 0, nwd = 0;
    int hs_cyc [0:7];
    int wd_cyc [0:7];
    for (int i = 0; i < 8; i++) begin hs_cyc[i] = 0; wd_cyc[i] = 0; end
    tdata = 16'h1234; tuser = 8'h00;
    @(negedge tb_data_clk);
    tvalid0 = 1'b1;
    for (int n = 0; n < 6400; n++) begin
      if (tvalid0 && rdy0) begin
        if (hs < 8) hs_cyc[hs] = n;
        hs++;
      end else if (hs >= 3) tvalid0 = 1'b0;
      if (wd0 === 1'b1) begin
        if (nwd < 8) wd_cyc[nwd] = n;
        nwd++;
      end
      @(negedge tb_data_clk);
    end
    tvalid0 = 1'b0;
    vectors++;
    if (nwd != 3 || hs != 3) begin
      miscompares++; $display("FAIL b2b_count: %0d word_done %0d handshakes required 3/3", nwd, hs);
    end
    vectors++;
    if (wd_cyc[0] - hs_cyc[0] != 2000) begin
      miscompares++; $display("FAIL b2b_first_latency: %0d required 2000", wd_cyc[0] - hs_cyc[0]);
    end
    vectors++;
    if (wd_cyc[1] - wd_cyc[0] != 2001 || wd_cyc[2] - wd_cyc[1] != 2001) begin
      miscompares++;
      $display("FAIL b2b_spacing: %0d/%0d required 2001/2001", wd_cyc[1] - wd_cyc[0], wd_cyc[2] - wd_cyc[1]);
    end
    vectors++;
    if (hs_cyc[1] - wd_cyc[0] != 1 || hs_cyc[2] - wd_cyc[1] != 1) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: %0d/%0d required 1/1", hs_cyc[1] - wd_cyc[0], hs_cyc[2] - wd_cyc[1]);
    end
  endtask

  task automatic test_abort();
    int w = 0, nwd = 0;
    @(negedge tb_data_clk);
    while (!rdy && w < 5000) begin @(negedge tb_data_clk); w++; end
    tdata = 16'h1234; tuser = 8'h01; tvalid = 1'b1;
    @(posedge tb_data_clk);
    #1 tvalid = 1'b0;
    for (int c = 1; c < 900; c++) begin
      @(negedge tb_data_clk);
      if (wd === 1'b1) nwd++;
    end
    @(negedge tb_data_clk);
    vectors++;
    if (diff === 2'b11 || busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_midword: diff=%b busy=%b required active word", diff, busy);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if (diff !== 2'b11) begin
      miscompares++; $display("FAIL abort_diff: got %b required 11", diff);
    end
    vectors++;
    if (busy !== 1'b0 || rdy !== 1'b0 || wd !== 1'b0) begin
      miscompares++; $display("FAIL abort_ctrl: busy=%b tready=%b word_done=%b required 0", busy, rdy, wd);
    end
    @(negedge tb_data_clk);
    arst = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge tb_data_clk);
      if (wd === 1'b1) nwd++;
    end
    vectors++;
    if (nwd != 0 || diff !== 2'b11 || rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_after: word_done=%0d diff=%b tready=%b required 0/11/1", nwd, diff, rdy);
    end
    test_encode("post_abort", 16'hA5C3, 8'h00, 1'b1);
  endtask

  task automatic test_loopback();
    logic [15:0] lb [0:7];
    logic [15:0] dec;
    logic        lv [0:39];
    logic        man_ok, sel;
    lb[0] = 16'h0000; lb[1] = 16'h0001; lb[2] = 16'h0055; lb[3] = 16'h00AA;
    lb[4] = 16'h007F; lb[5] = 16'h0080; lb[6] = 16'h00FE; lb[7] = 16'h00FF;
    for (int i = 0; i < 8; i++) begin
      sel = (i % 2 == 1);
      xfer(lb[i], {6'h2A, 1'b0, sel});
      for (int k = 0; k < 40; k++) lv[k] = cap_diff[k*H + H/2][0];
      dec = '0; man_ok = 1'b1;
      for (int b = 0; b < 16; b++) begin
        dec[15 - b] = lv[6 + 2*b];
        if (lv[7 + 2*b] === lv[6 + 2*b]) man_ok = 1'b0;
      end
      if (lv[39] === lv[38]) man_ok = 1'b0;
      vectors++;
      if (dec !== lb[i] || !man_ok) begin
        miscompares++; $display("FAIL loopback_data%0d: got %h manchester=%b required %h/1", i, dec, man_ok, lb[i]);
      end
      vectors++;
      if (lv[0] !== sel || lv[3] !== ~sel || ^{dec, lv[38]} !== 1'b1) begin
        miscompares++;
        $display("FAIL loopback_sync_parity%0d: sync=%b parity=%b required sync %b, odd parity", i, lv[0], lv[38], sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode("cmd_ffff", 16'hFFFF, 8'h01, 1'b1);
    test_encode("data_0000", 16'h0000, 8'h00, 1'b1);
    test_encode("parinv_0001", 16'h0001, 8'h02, 1'b1);
    test_back_to_back();
    test_abort();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_1553_encoder.md
AXIS_1553_ENCODER -- requirements
Module: axis_1553_encoder

Interface
REQ-001 The block SHALL have parameter CLOCK_SPEED, default 100000000, aclk frequency in Hz.
REQ-002 The block SHALL have parameter BIT_RATE, default 1000000, 1553 bit rate in Hz; CLOCK_SPEED/(2*BIT_RATE) is an integer ≥ 2, denoted H (cycles per half-bit).
REQ-003 The block SHALL have parameter GAP_BITS, default 4, the number of idle bit times after each word (range 0–255).
REQ-004 The block SHALL have parameter IDLE_DIFF, default 2'b11, the diff value driven when no word is active.
REQ-005 aclk  in  1  sole clock; all logic on the rising edge.
REQ-006 arst  in  1  asynchronous, active-high reset.
REQ-007 s_axis_tdata  in  16  data word to encode, MSB transmitted first.
REQ-008 s_axis_tuser  in  8  [0]=1 command/status sync, 0 data sync; [1]=1 invert parity (error injection); [7:2] ignored.
REQ-009 s_axis_tvalid  in  1  word available.
REQ-010 s_axis_tready  out  1  block accepts a word.
REQ-011 diff  out  2  differential Manchester output; diff[1] = ~diff[0] while a word is active.
REQ-012 busy  out  1  high from acceptance through the end of the gap.
REQ-013 word_done  out  1  one-cycle pulse on the last cycle of the parity bit.

Function
REQ-014 The FSM SHALL have the states IDLE, SYNC, DATA, PARITY and GAP.
REQ-015 Transitions: IDLE→SYNC on tvalid&tready; SYNC (6 half-bits)→DATA; DATA (32 half-bits)→PARITY; PARITY (2 half-bits)→GAP, or →IDLE when GAP_BITS=0; GAP (2*GAP_BITS half-bits)→IDLE.
REQ-016 s_axis_tready SHALL be high only in IDLE (registered); tdata/tuser are captured on the handshake cycle.
REQ-017 diff SHALL leave IDLE_DIFF on the first clock after the handshake (latency 1 cycle).
REQ-018 Command/status sync: diff[0]=1 for 3 half-bits, then 0 for 3 half-bits; data sync is the inverse.
REQ-019 Data bits are Manchester II: logic 1 = diff[0] high for the first half-bit, low for the second; logic 0 is the inverse.
REQ-020 Parity bit = ~^tdata (odd parity), XORed with tuser[1], encoded as in REQ-019.
REQ-021 A word SHALL last exactly 40*H cycles; each half-bit SHALL last exactly H cycles with no cumulative drift.
REQ-022 diff SHALL equal IDLE_DIFF in IDLE and GAP.
REQ-023 tvalid asserted during GAP SHALL NOT be accepted until IDLE; back-to-back words with GAP_BITS=0 SHALL have exactly 1 idle cycle between them.
REQ-024 tvalid deasserting without a handshake SHALL leave the block in IDLE with no output change.
REQ-025 The half-bit counter width is clog2(H); it wraps to 0 at H-1.
REQ-026 The gap counter width is clog2(2*GAP_BITS+1).

Reset
REQ-027 While arst is high: state=IDLE, diff=IDLE_DIFF, s_axis_tready=0, busy=0, word_done=0, counters=0, and captured registers=0.
REQ-028 Asserting arst mid-word SHALL abort the word immediately (asynchronously), with no word_done pulse.
REQ-029 s_axis_tready SHALL rise on the first aclk edge after arst deasserts.

Structure
REQ-030 The package pkg_1553 SHALL hold the FSM state encoding, the sync half-bit counts (6/32/2), and the SYNC_CMD/SYNC_DATA patterns, shared with axis_1553_decoder.
REQ-031 The sub-module util_1553_half_bit_tick SHALL generate a one-cycle tick every H cycles, restarted on handshake.

Verification
REQ-032 The bench SHALL cover the following scenarios (CLOCK_SPEED=100 MHz, BIT_RATE=1 MHz, H=50, GAP_BITS=4):
- tdata=16'hFFFF, tuser=1 → sync 150 cycles diff[0]=1 then 150 cycles 0; sixteen "1" bits; parity=1; word_done at cycle 2000; tready rises 400 cycles later.
- tdata=16'h0000, tuser=0 → data sync (low then high), sixteen "0" bits, parity=1.
- tdata=16'h0001, tuser=2 → parity bit 1 instead of 0 (inverted).
- tvalid held high, GAP_BITS=0, 3 words → 3 word_done pulses spaced 2001 cycles.
- arst asserted at cycle 900 of a word → diff=2'b11 in the same cycle, no word_done; next word encodes correctly.
- Loopback into axis_1553_decoder, tdata 16'h0000…16'h00FF → every m_axis_tdata matches, and tuser sync type matches.
